// File: rtl/filter_out_decimator.sv
// filter_out_decimator
//   Averages blocks of 2^shift consecutive filtered samples and queues one
//   decimated result per block in a small first-word-fall-through FIFO that
//   is drained over a valid/ready handshake. A sticky overflow flag records
//   any result lost because the FIFO was full.
//
// Build option:
//   DECIM_ROUND_EN  when defined, results are rounded half-up and saturated;
//                   when undefined, results are plain truncation.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   in_data      filtered sample
//   in_valid     sample qualifier (no backpressure upstream)
//   decim_shift  log2 decimation ratio, clamped to MAX_SHIFT
//   clear        synchronous flush of accumulator, FIFO and overflow
//   out_data     FIFO head (0 when empty)
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts out_data
//   overflow     sticky: a result was dropped on a full FIFO
//   fifo_level   FIFO occupancy, 0..DEPTH
//
// state | meaning
// IDLE  | no partial block held
// ACCUM | partial block held in acc, cnt samples so far
module filter_out_decimator #(
    parameter int DATA_W    = 16,
    parameter int MAX_SHIFT = 4,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic [2:0]               decim_shift,
    input  logic                     clear,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int ACC_W = DATA_W + MAX_SHIFT;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam logic [MAX_SHIFT:0] CNT_ONE = 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t               state, state_nxt;
    logic [ACC_W-1:0]     acc, acc_nxt;
    logic [MAX_SHIFT:0]   cnt, cnt_nxt, cnt_inc;
    logic [2:0]           shift_q, shift_nxt, shift_eff, shift_sel;
    logic [ACC_W-1:0]     sum;
    logic                 push;
    logic [DATA_W-1:0]    push_data;

    assign shift_eff = (decim_shift > 3'(MAX_SHIFT)) ? 3'(MAX_SHIFT) : decim_shift;
    // The first sample of a block uses the live shift; later ones use the latched one.
    assign shift_sel = (state == IDLE) ? shift_eff : shift_q;
    // Sum includes the current sample so the push needs no extra cycle.
    assign sum       = ((state == IDLE) ? '0 : acc) + ACC_W'(in_data);
    assign cnt_inc   = cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            shift_q <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            shift_q <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        shift_nxt = shift_q;
        push      = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    shift_nxt = shift_eff;
                    acc_nxt   = sum;
                    cnt_nxt   = CNT_ONE;
                    if (shift_eff == 3'd0) begin
                        push    = 1'b1;
                        acc_nxt = '0;
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_nxt = sum;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == (CNT_ONE << shift_q)) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef DECIM_ROUND_EN
    logic [ACC_W:0] rsum, rshift;
    always_comb begin
        rsum = {1'b0, sum};
        if (shift_sel != 3'd0)
            rsum = rsum + ((ACC_W+1)'(1) << (shift_sel - 3'd1));
        rshift = rsum >> shift_sel;
        if (rshift > (ACC_W+1)'({DATA_W{1'b1}}))
            push_data = '1;
        else
            push_data = DATA_W'(rshift);
    end
`else
    always_comb begin
        push_data = DATA_W'(sum >> shift_sel);
    end
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              pop, full, wr_en;

    assign out_valid = (fifo_level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;
    assign full      = (fifo_level == LW'(DEPTH));
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign wr_en     = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
            if (push && !wr_en)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear && wr_en)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_filter_out_decimator.sv
module tb_filter_out_decimator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  decim_shift = '0;
    logic        clear = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic [2:0]  fifo_level;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    filter_out_decimator #(.DATA_W(16), .MAX_SHIFT(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .decim_shift(decim_shift), .clear(clear), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
        .fifo_level(fifo_level)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; the monitor samples
    // on the falling edge, well clear of both.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && !clear && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", out_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_data: got %0d expected %0d", out_data, e);
                end
            end
        end
    end

    initial begin
        logic [15:0] round_exp;
        int budget;
        idle(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        idle(1);

        // Average of 4,8,12,16 over ratio 4
        decim_shift = 3'd2;
        send(16'd4); send(16'd8); send(16'd12);
        chk("t1_no_early_valid", out_valid, 0);
        exp_q.push_back(16'd10);
        send(16'd16);
        chk("t1_valid_after_last", out_valid, 1);
        chk("t1_level_1", fifo_level, 1);
        out_ready = 1'b1;
        step();
        chk("t1_level_0", fifo_level, 0);

        // Truncation vs rounding near full scale
        decim_shift = 3'd1;
`ifdef DECIM_ROUND_EN
        round_exp = 16'hFFFF;
`else
        round_exp = 16'hFFFE;
`endif
        send(16'hFFFF);
        exp_q.push_back(round_exp);
        send(16'hFFFE);
        idle(3);

        // Overflow: fill with 1..4, drop 5
        out_ready   = 1'b0;
        decim_shift = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(16'(i));
            send(16'(i));
        end
        chk("t3_level_full", fifo_level, 4);
        chk("t3_overflow_set", overflow, 1);
        out_ready = 1'b1;
        idle(6);
        chk("t3_drained", fifo_level, 0);
        chk("t3_overflow_sticky", overflow, 1);
        do_clear();
        chk("t3_overflow_cleared", overflow, 0);

        // Simultaneous push and pop while full
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(16'(i));
            send(16'(i));
        end
        chk("t4_level_full", fifo_level, 4);
        exp_q.push_back(16'd7);
        out_ready = 1'b1;
        send(16'd7);
        chk("t4_level_stays", fifo_level, 4);
        chk("t4_no_overflow", overflow, 0);
        idle(6);
        chk("t4_drained", fifo_level, 0);

        // Shift change mid-block applies to the next block only
        decim_shift = 3'd2;
        send(16'd0); send(16'd0);
        decim_shift = 3'd0;
        send(16'd8);
        exp_q.push_back(16'd4);
        send(16'd8);
        exp_q.push_back(16'd9);
        send(16'd9);
        idle(3);

        // Clamp: shift 7 behaves as 4 (ratio 16)
        decim_shift = 3'd7;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) exp_q.push_back(16'd3);
            send(16'd3);
        end
        idle(3);

        // Mid-block reset discards the partial sum
        decim_shift = 3'd2;
        send(16'd5); send(16'd5); send(16'd5);
        do_reset();
        chk("t6_rst_level", fifo_level, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(16'd20);
            send(16'd20);
        end
        idle(3);

        // Same with clear
        send(16'd5); send(16'd5); send(16'd5);
        do_clear();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(16'd20);
            send(16'd20);
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            step();
            budget++;
        end
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_level", fifo_level, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filter_out_decimator.md
Name: filter_out_decimator

Overview:
- Downstream stage of Digital_Filter; consumes its `data_out` stream, qualified by `ready`.
- Averages blocks of 2^shift consecutive filtered samples, producing one decimated sample per block.
- Results are buffered in a small FIFO and presented to the next consumer over a valid/ready handshake.
- Flags overflow when the consumer stalls long enough to fill the FIFO.

Parameters:
- DATA_W, 16, sample width; matches filter `data_out`.
- MAX_SHIFT, 4, largest supported log2 decimation ratio, so the maximum ratio is 16.
- DEPTH, 4, output FIFO entries; power of two, 2 or more.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  DATA_W  filtered sample; connects to filter `data_out`.
- in_valid  input  1  sample valid; connects to filter `ready`. There is no backpressure to the filter.
- decim_shift  input  3  log2 of the decimation ratio; values above MAX_SHIFT are clamped to MAX_SHIFT.
- clear  input  1  synchronous flush of accumulator, FIFO and overflow flag.
- out_data  output  DATA_W  decimated sample at the FIFO head.
- out_valid  output  1  FIFO is non-empty.
- out_ready  input  1  consumer accepts `out_data`.
- overflow  output  1  sticky flag: a result was dropped because the FIFO was full.
- fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FSM returns to IDLE; accumulator and sample counter go to 0.
  - FIFO is emptied: out_valid=0, out_data=0, fifo_level=0, overflow=0.
  - Reset mid-block discards the partial sum.
- Priority: rst_n, then clear, then normal operation. clear has the same effect as reset except that it needs rst_n=1.
- FSM states:
  - IDLE, meaning no partial block is held. On in_valid:
    - latch the effective shift into shift_q;
    - acc = in_data, cnt = 1;
    - if shift_q = 0, the block is complete immediately: push and stay in IDLE.
    - otherwise go to ACCUM.
  - ACCUM. On in_valid:
    - acc += in_data, cnt += 1;
    - when cnt reaches 2^shift_q, push the result and return to IDLE.
- decim_shift is sampled only on the first sample of a block; a change mid-block takes effect from the next block.
- Arithmetic:
  - Accumulator is DATA_W+MAX_SHIFT bits, unsigned, and cannot overflow.
  - Result = (acc + last in_data) >> shift_q, taken as the low DATA_W bits; default is truncation.
  - The push value includes the current sample combinationally, so no extra cycle is spent.
- Latency: a block's last sample accepted at edge t appears with out_valid=1 after edge t, provided the FIFO was empty.
- FIFO:
  - Registered head output; first-word-fall-through, so out_data is valid whenever out_valid=1.
  - A pop occurs when out_valid && out_ready; out_data and out_valid are held stable until then.
  - fifo_level always equals entries held, between 0 and DEPTH.
- Boundary conditions:
  - Push when full with no pop in the same cycle: the result is dropped, overflow is set to 1 and stays set until reset/clear; FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both succeed, level stays at DEPTH, no overflow.
  - Push and pop in the same cycle while empty: not possible, because the head is registered. The push lands in the FIFO and the pop is ignored since out_valid=0.
  - Read and write pointers wrap modulo DEPTH.
  - in_valid gaps of any length are allowed; the block accumulates across gaps.

Optional Feature:
- Macro: DECIM_ROUND_EN.
- Defined:
  - For shift_q>0, the result is (sum + 2^(shift_q-1)) >> shift_q, i.e. round-half-up.
  - The result saturates at 2^DATA_W-1.
  - shift_q=0 passes samples through unchanged.
- Undefined: plain truncation as in Behaviour, with no rounding adder synthesized.

Test Plan:
- Reset, then shift=2 with inputs 4,8,12,16 -> one output 10; out_valid rises the cycle after the 4th sample. fifo_level goes 0->1 and back to 0 after out_ready.
- shift=1, inputs 16'hFFFF,16'hFFFE -> output 16'hFFFE truncated. With DECIM_ROUND_EN -> 16'hFFFF, saturated via rounding.
- shift=0, out_ready=0, 5 samples 1..5 -> FIFO holds 1,2,3,4 with level 4; sample 5 dropped; overflow=1. out_ready=1 then drains 1,2,3,4 in order; overflow stays 1 until clear.
- FIFO full, shift=0, out_ready=1 while in_valid=1 with sample 7 -> pop and push in the same cycle; level stays 4; overflow stays 0; 7 drains last.
- shift=2, 2 samples accepted, then decim_shift changed to 0, then 2 more samples 8,8 with earlier 0,0 -> one output 4. The next single sample passes through at ratio 1.
- Mid-block: 3 of 4 samples accepted, then rst_n=0 for one cycle, then 4 samples of 20 -> output 20 with no stale contribution. Same check with clear instead of rst_n.
